// File: rtl/time_uart_tx.sv
// Serialises a snapshot of the 14 BCD time/date digits as "YYYY-MM-DD HH:MM:SS\r\n"
// over an 8N1 UART. One line is sent for each start request accepted while idle.
module time_uart_tx #(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [3:0] second_unit,
    input  logic [3:0] second_ten,
    input  logic [3:0] minute_unit,
    input  logic [3:0] minute_ten,
    input  logic [3:0] hour_unit,
    input  logic [3:0] hour_ten,
    input  logic [3:0] day_unit,
    input  logic [3:0] day_ten,
    input  logic [3:0] month_unit,
    input  logic [3:0] month_ten,
    input  logic [3:0] year_unit,
    input  logic [3:0] year_ten,
    input  logic [3:0] year_hundered,
    input  logic [3:0] year_thousand,
    output logic       tx,
    output logic       busy,
    output logic       done
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [4:0]    LAST_CHAR = 5'd20;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] START = 2'd1;
    localparam logic [1:0] DATA  = 2'd2;
    localparam logic [1:0] STOP  = 2'd3;

    logic [1:0]    state;
    logic [CW-1:0] baud_cnt;
    logic [2:0]    bit_idx;
    logic [4:0]    char_idx;
    logic [55:0]   snap;
    logic [7:0]    shreg;
    logic [7:0]    cur_char;

    function automatic logic [7:0] enc(input logic [3:0] d);
        return (d <= 4'd9) ? {4'h3, d} : 8'h3F;
    endfunction

    always_comb begin
        cur_char = 8'h0A;
        case (char_idx)
            5'd0:    cur_char = enc(snap[55:52]);
            5'd1:    cur_char = enc(snap[51:48]);
            5'd2:    cur_char = enc(snap[47:44]);
            5'd3:    cur_char = enc(snap[43:40]);
            5'd4:    cur_char = 8'h2D;
            5'd5:    cur_char = enc(snap[39:36]);
            5'd6:    cur_char = enc(snap[35:32]);
            5'd7:    cur_char = 8'h2D;
            5'd8:    cur_char = enc(snap[31:28]);
            5'd9:    cur_char = enc(snap[27:24]);
            5'd10:   cur_char = 8'h20;
            5'd11:   cur_char = enc(snap[23:20]);
            5'd12:   cur_char = enc(snap[19:16]);
            5'd13:   cur_char = 8'h3A;
            5'd14:   cur_char = enc(snap[15:12]);
            5'd15:   cur_char = enc(snap[11:8]);
            5'd16:   cur_char = 8'h3A;
            5'd17:   cur_char = enc(snap[7:4]);
            5'd18:   cur_char = enc(snap[3:0]);
            5'd19:   cur_char = 8'h0D;
            default: cur_char = 8'h0A;
        endcase
    end

    // tx is loaded one edge ahead of each bit period, so the line is driven from a flop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            baud_cnt <= '0;
            bit_idx  <= '0;
            char_idx <= '0;
            snap     <= '0;
            shreg    <= '0;
            tx       <= 1'b1;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        snap     <= {year_thousand, year_hundered, year_ten, year_unit,
                                     month_ten, month_unit, day_ten, day_unit,
                                     hour_ten, hour_unit, minute_ten, minute_unit,
                                     second_ten, second_unit};
                        state    <= START;
                        tx       <= 1'b0;
                        busy     <= 1'b1;
                        baud_cnt <= '0;
                        bit_idx  <= '0;
                        char_idx <= '0;
                    end
                end
                START: begin
                    if (baud_cnt == BAUD_LAST) begin
                        baud_cnt <= '0;
                        bit_idx  <= '0;
                        shreg    <= cur_char;
                        tx       <= cur_char[0];
                        state    <= DATA;
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (baud_cnt == BAUD_LAST) begin
                        baud_cnt <= '0;
                        if (bit_idx == 3'd7) begin
                            tx    <= 1'b1;
                            state <= STOP;
                        end else begin
                            bit_idx <= bit_idx + 1'b1;
                            shreg   <= shreg >> 1;
                            tx      <= shreg[1];
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                default: begin
                    if (baud_cnt == BAUD_LAST) begin
                        baud_cnt <= '0;
                        if (char_idx == LAST_CHAR) begin
                            char_idx <= '0;
                            state    <= IDLE;
                            busy     <= 1'b0;
                            done     <= 1'b1;
                        end else begin
                            char_idx <= char_idx + 1'b1;
                            tx       <= 1'b0;
                            state    <= START;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_time_uart_tx.sv
// Directed bench for time_uart_tx at 4 clocks per bit: table of lines plus
// hand sequences for restart-on-done and mid-frame reset.
module tb_time_uart_tx;

    localparam int CPB      = 4;
    localparam int LINE_CYC = 210 * CPB;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [55:0] digits = '0;
    logic        tx, busy, done;

    int n_cmp = 0;
    int n_bad = 0;

    logic tx_log   [0:1023];
    logic busy_log [0:1023];
    logic done_log [0:1023];

    typedef struct {
        string        name;
        logic [55:0]  digits;
        int           poke_kind;
        int           poke_cycle;
        logic [167:0] exp_line;
    } vec_t;

    vec_t vecs [5];

    always #5 clk = ~clk;

    time_uart_tx #(.CLKS_PER_BIT(CPB)) dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .second_unit   (digits[3:0]),
        .second_ten    (digits[7:4]),
        .minute_unit   (digits[11:8]),
        .minute_ten    (digits[15:12]),
        .hour_unit     (digits[19:16]),
        .hour_ten      (digits[23:20]),
        .day_unit      (digits[27:24]),
        .day_ten       (digits[31:28]),
        .month_unit    (digits[35:32]),
        .month_ten     (digits[39:36]),
        .year_unit     (digits[43:40]),
        .year_ten      (digits[47:44]),
        .year_hundered (digits[51:48]),
        .year_thousand (digits[55:52]),
        .tx            (tx),
        .busy          (busy),
        .done          (done)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    // Returns with the accept edge just taken; the next negedge is cycle 1.
    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
    endtask

    // kinds: 0 none, 1 digits->9, 2 start while busy, 3 reset, 4 restart in done cycle
    task automatic capture(input int kind, input int poke_cycle, output int dc);
        dc = -1;
        for (int n = 1; n <= 1000; n++) begin
            @(negedge clk);
            if (n == 1) start = 1'b0;
            tx_log[n]   = tx;
            busy_log[n] = busy;
            done_log[n] = done;
            if (n == poke_cycle) begin
                case (kind)
                    1: digits = {14{4'h9}};
                    2: start = 1'b1;
                    3: begin
                        rst = 1'b1;
                        #1;
                        chk("reset_mid_tx", {63'd0, tx}, 64'd1);
                        chk("reset_mid_busy", {63'd0, busy}, 64'd0);
                        chk("reset_mid_done", {63'd0, done}, 64'd0);
                        dc = 0;
                        break;
                    end
                    default: ;
                endcase
            end
            if (kind == 2 && n == poke_cycle + 1) start = 1'b0;
            if (done) begin
                dc = n;
                if (kind == 4) start = 1'b1;
                break;
            end
        end
    endtask

    task automatic check_line(input string name, input logic [167:0] exp, input int dc);
        logic [167:0] line;
        logic [7:0]   eb, got;
        int           wbad, c, p;
        logic         ebit;
        line = exp;
        chk({name, "_done_cycle"}, 64'(dc), 64'(LINE_CYC + 1));
        if (dc == LINE_CYC + 1) begin
            wbad = 0;
            for (int n = 1; n <= LINE_CYC; n++) begin
                c  = (n - 1) / (10 * CPB);
                p  = ((n - 1) % (10 * CPB)) / CPB;
                eb = line[167 - 8 * c -: 8];
                ebit = (p == 0) ? 1'b0 : (p == 9) ? 1'b1 : eb[p - 1];
                if (tx_log[n] !== ebit || busy_log[n] !== 1'b1 || done_log[n] !== 1'b0)
                    wbad++;
            end
            chk({name, "_waveform_errs"}, 64'(wbad), 64'd0);
            for (int ci = 0; ci < 21; ci++) begin
                got = '0;
                for (int b = 0; b < 8; b++)
                    got[b] = tx_log[1 + ci * 10 * CPB + (b + 1) * CPB + CPB / 2];
                chk($sformatf("%s_char%0d", name, ci), {56'd0, got}, {56'd0, line[167 - 8 * ci -: 8]});
            end
            chk({name, "_done_tx"}, {62'd0, tx_log[dc], busy_log[dc]}, 64'b10);
        end
    endtask

    initial begin
        int           dc;
        int           idle_bad;
        logic [0:9]   first_bits;
        logic [167:0] norm_line;

        norm_line = {"2024-03-15 09:41:07", 8'h0D, 8'h0A};
        vecs[0] = '{"normal",   56'h20240315094107, 0, 0,   norm_line};
        vecs[1] = '{"snapshot", 56'h20240315094107, 1, 100, norm_line};
        vecs[2] = '{"invalid",  56'h20240C15094107, 0, 0,
                    {"2024-0?-15 09:41:07", 8'h0D, 8'h0A}};
        vecs[3] = '{"busy_start", 56'h20240315094107, 2, 200, norm_line};
        vecs[4] = '{"eoy",      56'h19991231235959, 0, 0,
                    {"1999-12-31 23:59:59", 8'h0D, 8'h0A}};

        repeat (3) @(negedge clk);
        chk("reset_state", {61'd0, tx, busy, done}, 64'b100);
        rst = 1'b0;
        repeat (3) @(negedge clk);

        for (int v = 0; v < 5; v++) begin
            digits = vecs[v].digits;
            pulse_start();
            capture(vecs[v].poke_kind, vecs[v].poke_cycle, dc);
            check_line(vecs[v].name, vecs[v].exp_line, dc);
            if (v == 0) begin
                first_bits = 10'b0010011001;
                for (int n = 1; n <= 10 * CPB; n++)
                    chk($sformatf("first_bits_c%0d", n), {63'd0, tx_log[n]},
                        {63'd0, first_bits[(n - 1) / CPB]});
            end
            idle_bad = 0;
            for (int k = 0; k < 60; k++) begin
                @(negedge clk);
                if (busy !== 1'b0 || tx !== 1'b1 || done !== 1'b0) idle_bad++;
            end
            chk({vecs[v].name, "_idle_after"}, 64'(idle_bad), 64'd0);
        end

        // Restart in the done cycle: second line starts at done+1.
        digits = 56'h20240315094107;
        pulse_start();
        capture(4, 0, dc);
        check_line("restart_first", norm_line, dc);
        @(posedge clk);
        capture(0, 0, dc);
        chk("restart_tx_at_done_plus1", {62'd0, tx_log[1], busy_log[1]}, 64'b01);
        check_line("restart_second", norm_line, dc);

        // Mid-frame reset, then a fresh line.
        pulse_start();
        capture(3, 300, dc);
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        chk("post_reset_idle", {62'd0, tx, busy}, 64'b10);
        pulse_start();
        capture(0, 0, dc);
        check_line("after_reset", norm_line, dc);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
